// File: rtl/mem_map_pkg.sv
// Address map constants and small helpers shared by the memory/IO responder.
package mem_map_pkg;

   localparam logic [1:0]  IO_SEL       = 2'b11;
   localparam logic [17:0] IO_UART_ADDR = 18'h30000;
   localparam logic [17:0] IO_CLK_ADDR  = 18'h30004;
   localparam int          RAM_BYTES    = 131072;

   function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
      word_byte = w[7:0];
      case (idx)
         2'd1: word_byte = w[15:8];
         2'd2: word_byte = w[23:16];
         2'd3: word_byte = w[31:24];
         default: word_byte = w[7:0];
      endcase
   endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with combinational head output; DEPTH must be a power of two.
module byte_fifo #(
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [7:0]    din,
   output logic [7:0]    dout,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);

   localparam logic [AW-1:0] PTR_ONE = 1;
   localparam logic [AW:0]   CNT_ONE = 1;
   localparam logic [AW:0]   CNT_MAX = DEPTH;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   assign dout  = mem[rd_ptr];
   assign full  = (count == CNT_MAX);
   assign empty = (count == '0);

endmodule

// File: rtl/mem_io_responder.sv
// Byte RAM plus memory-mapped UART/cycle-counter/stop registers behind the CPU bus.
// Build option: define MEM_RESP_RX_EN to include the RX holding register.
module mem_io_responder
   import mem_map_pkg::*;
#(
   parameter int ADDR_WIDTH = $clog2(RAM_BYTES),
   parameter int TX_DEPTH   = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_rdy,
   input  logic [31:0] mem_a,
   input  logic [7:0]  mem_dout,
   input  logic        mem_wr,
   output logic [7:0]  mem_din,
   output logic        io_buffer_full,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   output logic        prog_stop,
   output logic        tx_overflow
);

   localparam int CW = $clog2(TX_DEPTH) + 1;
   localparam logic [CW-1:0] CNT_ONE   = 1;
   localparam logic [CW-1:0] NEAR_FULL = CW'(TX_DEPTH - 2);

   logic [17:0]           addr;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic                  io_sel, uart_sel, clk_sel, snap_sel;
   logic                  wr_en, rd_en;

   assign addr     = mem_a[17:0];
   assign ram_addr = mem_a[ADDR_WIDTH-1:0];
   assign io_sel   = (addr[17:16] == IO_SEL);
   assign uart_sel = io_sel && (addr == IO_UART_ADDR);
   assign clk_sel  = io_sel && (addr == IO_CLK_ADDR);
   assign snap_sel = io_sel && (addr[17:2] == IO_CLK_ADDR[17:2]) && (addr[1:0] != 2'd0);
   assign wr_en    = mem_wr & cpu_rdy;
   assign rd_en    = ~mem_wr;

   // RAM: read-before-write in one block so it maps onto a synchronous RAM macro
   logic [7:0] ram [2**ADDR_WIDTH];
   logic [7:0] ram_q;

   always_ff @(posedge clk) begin
      if (wr_en && !io_sel) ram[ram_addr] <= mem_dout;
      ram_q <= ram[ram_addr];
   end

   logic          tx_wr, tx_push, tx_pop, tx_drop;
   logic          tx_full, tx_empty;
   logic [7:0]    tx_head;
   logic [CW-1:0] tx_count, tx_count_next;

   assign tx_wr   = wr_en && uart_sel && (mem_dout != 8'h00);
   assign tx_pop  = tx_valid & tx_ready;
   assign tx_push = tx_wr & (~tx_full | tx_pop);
   assign tx_drop = tx_wr & tx_full & ~tx_pop;

   byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (tx_push),
      .pop   (tx_pop),
      .din   (mem_dout),
      .dout  (tx_head),
      .full  (tx_full),
      .empty (tx_empty),
      .count (tx_count)
   );

   assign tx_valid = ~tx_empty;
   assign tx_data  = tx_empty ? 8'h00 : tx_head;

   always_comb begin
      tx_count_next = tx_count;
      if (tx_push && !tx_pop)      tx_count_next = tx_count + CNT_ONE;
      else if (!tx_push && tx_pop) tx_count_next = tx_count - CNT_ONE;
   end

   logic       rx_take;
   logic [7:0] rx_rdata;

   assign rx_take = rd_en & cpu_rdy & uart_sel;

`ifdef MEM_RESP_RX_EN
   logic       rx_full;
   logic [7:0] rx_hold;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_full <= 1'b0;
         rx_hold <= 8'h00;
      end else if (rx_valid && !rx_full) begin
         rx_full <= 1'b1;
         rx_hold <= rx_data;
      end else if (rx_take) begin
         rx_full <= 1'b0;
      end
   end

   assign rx_ready = ~rx_full;
   assign rx_rdata = rx_full ? rx_hold : 8'h00;
   logic unused_bits;
   assign unused_bits = ^mem_a[31:18];
`else
   assign rx_ready = 1'b0;
   assign rx_rdata = 8'h00;
   logic unused_bits;
   assign unused_bits = ^{mem_a[31:18], rx_valid, rx_data, rx_take};
`endif

   logic [31:0] cycle_cnt;
   logic [31:0] snap;
   logic        snap_take;
   logic [7:0]  io_rdata;

   assign snap_take = rd_en & cpu_rdy & clk_sel;

   // a snapshotting read returns the live counter byte that is being captured
   always_comb begin
      io_rdata = 8'h00;
      if (uart_sel)      io_rdata = rx_rdata;
      else if (clk_sel)  io_rdata = snap_take ? cycle_cnt[7:0] : snap[7:0];
      else if (snap_sel) io_rdata = word_byte(snap, addr[1:0]);
   end

   logic       rd_ram;
   logic [7:0] io_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ram         <= 1'b0;
         io_q           <= 8'h00;
         cycle_cnt      <= '0;
         snap           <= '0;
         prog_stop      <= 1'b0;
         tx_overflow    <= 1'b0;
         io_buffer_full <= 1'b0;
      end else begin
         rd_ram         <= ~io_sel;
         io_q           <= io_rdata;
         cycle_cnt      <= cycle_cnt + 32'd1;
         if (snap_take) snap <= cycle_cnt;
         if (wr_en && clk_sel) prog_stop <= 1'b1;
         if (tx_drop) tx_overflow <= 1'b1;
         io_buffer_full <= (tx_count_next >= NEAR_FULL);
      end
   end

   assign mem_din = rd_ram ? ram_q : io_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder with a queue/array reference model.
module tb_mem_io_responder;

   localparam int DEPTH = 16;
`ifdef MEM_RESP_RX_EN
   localparam bit RX_EN = 1'b1;
`else
   localparam bit RX_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cpu_rdy = 1'b1;
   logic [31:0] mem_a = '0;
   logic [7:0]  mem_dout = '0;
   logic        mem_wr = 1'b0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        tx_ready = 1'b0;
   logic [7:0]  mem_din;
   logic        io_buffer_full, rx_ready, tx_valid, prog_stop, tx_overflow;
   logic [7:0]  tx_data;

   mem_io_responder #(.ADDR_WIDTH(17), .TX_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .cpu_rdy(cpu_rdy), .mem_a(mem_a), .mem_dout(mem_dout),
      .mem_wr(mem_wr), .mem_din(mem_din), .io_buffer_full(io_buffer_full),
      .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .prog_stop(prog_stop), .tx_overflow(tx_overflow)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // reference model
   logic [7:0]  ram_m [int];
   logic [7:0]  txq [$];
   logic [31:0] m_cnt = 0, m_snap = 0;
   bit          m_rx_full = 0, m_stop = 0, m_ovf = 0, m_din_vld = 1;
   logic [7:0]  m_rx = 0, m_din = 0;
   logic [17:0] ma;
   bit          mio, mpop, mrxf;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         txq.delete();
         m_cnt = 0; m_snap = 0; m_rx_full = 0; m_rx = 0;
         m_stop = 0; m_ovf = 0; m_din = 0; m_din_vld = 1;
      end else begin
         ma   = mem_a[17:0];
         mio  = (ma[17:16] == 2'b11);
         mpop = tx_ready && (txq.size() > 0);
         mrxf = m_rx_full;
         m_din_vld = 0;
         if (!mem_wr) begin
            m_din_vld = 1;
            m_din = 8'h00;
            if (!mio) begin
               if (ram_m.exists(int'(ma[16:0]))) m_din = ram_m[int'(ma[16:0])];
               else m_din_vld = 0;
            end else if (ma == 18'h30000) begin
               if (RX_EN && m_rx_full) m_din = m_rx;
               if (RX_EN && cpu_rdy) m_rx_full = 0;
            end else if (ma == 18'h30004) begin
               if (cpu_rdy) m_snap = m_cnt;
               m_din = m_snap[7:0];
            end else if (ma >= 18'h30005 && ma <= 18'h30007) begin
               m_din = 8'(m_snap >> (8 * int'(ma[1:0])));
            end
         end
         if (mem_wr && cpu_rdy) begin
            if (!mio) ram_m[int'(ma[16:0])] = mem_dout;
            else if (ma == 18'h30000 && mem_dout != 8'h00) begin
               if (txq.size() < DEPTH || mpop) txq.push_back(mem_dout);
               else m_ovf = 1;
            end else if (ma == 18'h30004) m_stop = 1;
         end
         if (mpop) void'(txq.pop_front());
         if (RX_EN && rx_valid && !mrxf) begin
            m_rx_full = 1;
            m_rx = rx_data;
         end
         m_cnt = m_cnt + 1;
      end
   end

   always @(negedge clk) begin
      if (m_din_vld) check("mem_din", mem_din, m_din);
      check("tx_valid", tx_valid, txq.size() > 0);
      check("tx_data", tx_data, (txq.size() > 0) ? txq[0] : 8'h00);
      check("io_buffer_full", io_buffer_full, txq.size() >= DEPTH - 2);
      check("rx_ready", rx_ready, RX_EN ? !m_rx_full : 1'b0);
      check("prog_stop", prog_stop, m_stop);
      check("tx_overflow", tx_overflow, m_ovf);
   end

   logic [7:0] popped [$];
   always @(posedge clk) if (rst && tx_valid && tx_ready) popped.push_back(tx_data);

   task automatic op(input logic [31:0] a, input logic [7:0] d, input logic wr, input logic rdy);
      mem_a = a; mem_dout = d; mem_wr = wr; cpu_rdy = rdy;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) op(32'h0, 8'h00, 1'b0, 1'b1);
   endtask

   task automatic do_reset();
      mem_a = '0; mem_wr = 1'b0; cpu_rdy = 1'b1; mem_dout = '0;
      #2 rst = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_tx_overflow", tx_overflow, 1'b0);
      check("rst_tx_valid", tx_valid, 1'b0);
      check("rst_buf_full", io_buffer_full, 1'b0);
      check("rst_prog_stop", prog_stop, 1'b0);
      #2 rst = 1'b1;
      @(negedge clk);
   endtask

   logic [31:0] snapv;

   initial begin
      #1 rst = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_mem_din", mem_din, 8'h00);
      check("rst_rx_ready", rx_ready, RX_EN);
      check("rst_tx_data", tx_data, 8'h00);
      #2 rst = 1'b1;
      @(negedge clk);

      // cycle counter snapshot after ~1000 cycles
      idle(1000);
      op(32'h30004, 8'h00, 1'b0, 1'b1); snapv[7:0]   = mem_din;
      op(32'h30005, 8'h00, 1'b0, 1'b1); snapv[15:8]  = mem_din;
      op(32'h30006, 8'h00, 1'b0, 1'b1); snapv[23:16] = mem_din;
      op(32'h30007, 8'h00, 1'b0, 1'b1); snapv[31:24] = mem_din;
      check("cnt_in_range", (snapv >= 32'd1000) && (snapv <= 32'd1004), 1'b1);
      idle(3);
      op(32'h30006, 8'h00, 1'b0, 1'b1);
      check("cnt_stale_byte2", mem_din, snapv[23:16]);
      op(32'h30004, 8'h00, 1'b0, 1'b0);
      check("cnt_no_rdy_stale", mem_din, snapv[7:0]);

      // RAM
      op(32'h0000_0100, 8'hA5, 1'b1, 1'b1);
      op(32'h0000_0100, 8'h00, 1'b0, 1'b1);
      check("ram_a5", mem_din, 8'hA5);
      op(32'h0000_0100, 8'h11, 1'b1, 1'b0);
      op(32'h0000_0100, 8'h00, 1'b0, 1'b1);
      check("ram_wr_gated", mem_din, 8'hA5);
      op(32'h0001_FFFF, 8'h3C, 1'b1, 1'b1);
      op(32'h0000_0000, 8'hC3, 1'b1, 1'b1);
      op(32'h1234_0000, 8'h00, 1'b0, 1'b1);
      op(32'h0001_FFFF, 8'h00, 1'b0, 1'b1);
      op(32'hFFFC_0000, 8'h00, 1'b0, 1'b1);
      check("ram_alias_top_bits", mem_din, 8'hC3);

      // TX with zero filtering
      tx_ready = 1'b1;
      popped.delete();
      op(32'h30000, 8'h41, 1'b1, 1'b1);
      op(32'h30000, 8'h00, 1'b1, 1'b1);
      op(32'h30000, 8'h42, 1'b1, 1'b1);
      idle(3);
      check("tx_seq_len", popped.size(), 2);
      if (popped.size() == 2) begin
         check("tx_seq0", popped[0], 8'h41);
         check("tx_seq1", popped[1], 8'h42);
      end

      // fill and overflow
      tx_ready = 1'b0;
      for (int i = 1; i <= 17; i++) begin
         op(32'h30000, 8'(i), 1'b1, 1'b1);
         if (i == 13) check("ibf_after_13", io_buffer_full, 1'b0);
         if (i == 14) check("ibf_after_14", io_buffer_full, 1'b1);
         if (i == 16) check("ovf_after_16", tx_overflow, 1'b0);
         if (i == 17) check("ovf_after_17", tx_overflow, 1'b1);
      end
      check("fifo_head_first", tx_data, 8'h01);
      op(32'h30000, 8'h00, 1'b0, 1'b1);
      do_reset();

      // push and pop on a full FIFO
      for (int i = 1; i <= 16; i++) op(32'h30000, 8'(8'h20 + i), 1'b1, 1'b1);
      tx_ready = 1'b1;
      popped.delete();
      op(32'h30000, 8'h55, 1'b1, 1'b1);
      check("full_push_pop_no_ovf", tx_overflow, 1'b0);
      idle(20);
      check("drain_len", popped.size(), 17);
      if (popped.size() == 17) begin
         check("drain_first", popped[0], 8'h21);
         check("drain_last", popped[16], 8'h55);
      end

      // cpu_rdy gating of TX writes
      popped.delete();
      for (int i = 0; i < 5; i++) op(32'h30000, 8'h66, 1'b1, 1'b0);
      op(32'h30000, 8'h66, 1'b1, 1'b1);
      idle(3);
      check("rdy_gate_len", popped.size(), 1);

      // prog_stop and other IO
      op(32'h30008, 8'hFF, 1'b1, 1'b1);
      check("other_io_wr_ignored", prog_stop, 1'b0);
      tx_ready = 1'b0;
      op(32'h30000, 8'h77, 1'b1, 1'b1);
      op(32'h30004, 8'h01, 1'b1, 1'b1);
      check("prog_stop_set", prog_stop, 1'b1);
      tx_ready = 1'b1;
      idle(2);
      check("drain_after_stop", tx_valid, 1'b0);
      op(32'h30010, 8'h00, 1'b0, 1'b1);
      check("other_io_rd_zero", mem_din, 8'h00);

      // RX path
      rx_data = 8'h7F; rx_valid = 1'b1;
      idle(1);
      rx_valid = 1'b0;
`ifdef MEM_RESP_RX_EN
      check("rx_ready_busy", rx_ready, 1'b0);
      op(32'h30000, 8'h00, 1'b0, 1'b1);
      check("rx_read", mem_din, 8'h7F);
      check("rx_ready_back", rx_ready, 1'b1);
      op(32'h30000, 8'h00, 1'b0, 1'b1);
      check("rx_read_empty", mem_din, 8'h00);
`else
      check("rx_ready_tied", rx_ready, 1'b0);
      op(32'h30000, 8'h00, 1'b0, 1'b1);
      check("rx_read_disabled", mem_din, 8'h00);
`endif
      do_reset();
      idle(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
